// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Frame state encoding, default baud divider and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int CLKS_PER_BIT_DEFAULT = 87;
  localparam int UART_DATA_W = 8;

  // data must already be masked to the frame width
  function automatic logic frame_parity(
    input logic [UART_DATA_W-1:0] data,
    input logic                   odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick in the last cycle of each bit period.
// Ports: clk, nrst (async low), restart (hold count at 0), tick.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic nrst,
  input  logic restart,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign tick = (count == LAST);

  // every non-idle state change lands on a tick, so the
  // wrap to zero doubles as the restart for the next state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start, data LSB-first, parity, stop.
// Ports: clk, nrst, tx_data/tx_valid/tx_ready, busy, done, txd, cnt_*.
import uart_pkg::*;

module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   txd,
  output logic                   cnt_enable,
  output logic                   cnt_clear,
  input  logic [3:0]             cnt_value
);

  localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);
  localparam logic [UART_DATA_W-1:0] DATA_MASK =
    UART_DATA_W'((1 << DATA_BITS) - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic ODD = 1'(PARITY_ODD);

  tx_state_t              state;
  logic [UART_DATA_W-1:0] shift;
  logic                   par;
  logic                   stop_cnt;
  logic                   tick;
  logic                   last_bit;

  // out-of-range index also ends DATA
  assign last_bit = (cnt_value >= LAST_IDX);

  assign tx_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign cnt_clear  = (state == IDLE) || (state == START);
  assign cnt_enable = (state == DATA) && tick && !last_bit;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .nrst   (nrst),
    .restart(state == IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      done     <= 1'b0;
      shift    <= '0;
      par      <= 1'b0;
      stop_cnt <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            shift <= tx_data & DATA_MASK;
            par   <= frame_parity(tx_data & DATA_MASK, ODD);
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            txd   <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift <= shift >> 1;
            if (last_bit) begin
              stop_cnt <= 1'b0;
              if (PARITY_EN != 0) begin
                txd   <= par;
                state <= PARITY;
              end else begin
                txd   <= 1'b1;
                state <= STOP;
              end
            end else begin
              txd <= shift[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            txd      <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt == STOP_LAST) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four parameter sets, queued
// expected frames, per-instance line monitors.
module tb_uart_tx_ctrl;

  localparam int C = 4;
  // instance k: 0 plain, 1 even parity, 2 odd parity, 3 two stop bits
  localparam logic [3:0] PEN   = 4'b0110;
  localparam logic [3:0] PODD  = 4'b0100;
  localparam logic [3:0] STOP2 = 4'b1000;

  typedef struct {
    logic [7:0] d;
    bit         b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic [3:0] nrst_w;
  logic [3:0] valid_w;
  logic [3:0] ready_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;
  logic [3:0] txd_w;
  logic [3:0] en_w;
  logic [3:0] clr_w;
  logic [7:0] data_w [4];
  logic [3:0] cnt_w [4];

  exp_t exp_q [4][$];
  bit   active [4];
  int   done_n [4];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_ctrl #(
      .CLKS_PER_BIT(C),
      .DATA_BITS   (8),
      .PARITY_EN   (int'(PEN[g])),
      .PARITY_ODD  (int'(PODD[g])),
      .STOP_BITS   (STOP2[g] ? 2 : 1)
    ) dut (
      .clk       (clk),
      .nrst      (nrst_w[g]),
      .tx_data   (data_w[g]),
      .tx_valid  (valid_w[g]),
      .tx_ready  (ready_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .txd       (txd_w[g]),
      .cnt_enable(en_w[g]),
      .cnt_clear (clr_w[g]),
      .cnt_value (cnt_w[g])
    );
  end

  // external 4-bit counter: clear wins over enable
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (clr_w[k]) cnt_w[k] <= '0;
      else if (en_w[k]) cnt_w[k] <= cnt_w[k] + 4'd1;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      if (done_w[k] === 1'b1) done_n[k] = done_n[k] + 1;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic mon(input int k);
    exp_t e;
    bit   bits[$];
    int   idle, nc, bi, cnt_bad, done_bad, s;
    bit   bad, aborted;
    s = STOP2[k] ? 2 : 1;
    idle = 0;
    forever begin
      @(negedge clk);
      if (!nrst_w[k] || txd_w[k] !== 1'b0) begin
        idle++;
        continue;
      end
      if (exp_q[k].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL inst%0d unexpected start bit at %0t", k, $time);
        continue;
      end
      e = exp_q[k].pop_front();
      active[k] = 1'b1;
      if (e.b2b)
        chk($sformatf("inst%0d b2b high-line cycles", k),
            idle + s*C + 1, s*C + 1);
      bits.delete();
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(e.d[i]);
      if (PEN[k])
        bits.push_back(1'(($countones(e.d) % 2) ^ int'(PODD[k])));
      repeat (s) bits.push_back(1'b1);
      nc = bits.size() * C;
      aborted = 0; bad = 0; cnt_bad = 0; done_bad = 0;
      for (int c = 1; c <= nc; c++) begin
        if (c > 1) @(negedge clk);
        if (!nrst_w[k]) begin
          aborted = 1;
          break;
        end
        bi = (c - 1) / C;
        if (txd_w[k] !== bits[bi]) bad = 1;
        if (done_w[k] !== 1'b0) done_bad++;
        if (bi >= 1 && bi <= 8 && (c % C) == 0 &&
            cnt_w[k] != 4'(bi - 1)) cnt_bad++;
        if ((c % C) == 0) begin
          checks++;
          if (bad) begin
            errors++;
            $display("FAIL inst%0d frame 0x%h bit%0d: txd=%b want %b",
                     k, e.d, bi, txd_w[k], bits[bi]);
          end
          bad = 0;
        end
      end
      if (!aborted) begin
        chk($sformatf("inst%0d cnt_value steps 0x%h", k, e.d), cnt_bad, 0);
        chk($sformatf("inst%0d early done 0x%h", k, e.d), done_bad, 0);
        @(negedge clk);
        chk($sformatf("inst%0d done pulse 0x%h", k, e.d),
            int'(done_w[k]), 1);
      end
      active[k] = 1'b0;
      idle = 0;
    end
  endtask

  task automatic send(input int k, input logic [7:0] d,
                      input bit b2b, input bit hold);
    int t;
    exp_t e;
    @(negedge clk);
    data_w[k] = d;
    valid_w[k] = 1'b1;
    t = 0;
    while (!ready_w[k] && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      chk($sformatf("inst%0d handshake timeout", k), 0, 1);
      valid_w[k] = 1'b0;
      return;
    end
    e.d = d;
    e.b2b = b2b;
    exp_q[k].push_back(e);
    @(posedge clk);
    #1;
    if (!hold) valid_w[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((!ready_w[k] || exp_q[k].size() != 0 || active[k])
               && t < 2000);
    if (t >= 2000) chk($sformatf("inst%0d idle timeout", k), 0, 1);
    #1;
  endtask

  task automatic rand_run(input int k);
    bit hold, prev;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      hold = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(k, 8'($urandom), prev, hold);
      prev = hold;
      if (!hold) repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_idle(k);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    nrst_w  = '0;
    valid_w = '0;
    for (int k = 0; k < 4; k++) begin
      data_w[k] = '0;
      done_n[k] = 0;
      active[k] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      fork
        automatic int kk = k;
        mon(kk);
      join_none
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("inst%0d rst txd", k), int'(txd_w[k]), 1);
      chk($sformatf("inst%0d rst tx_ready", k), int'(ready_w[k]), 1);
      chk($sformatf("inst%0d rst busy", k), int'(busy_w[k]), 0);
      chk($sformatf("inst%0d rst done", k), int'(done_w[k]), 0);
      chk($sformatf("inst%0d rst cnt_clear", k), int'(clr_w[k]), 1);
      chk($sformatf("inst%0d rst cnt_enable", k), int'(en_w[k]), 0);
    end
    nrst_w = '1;

    send(0, 8'hA5, 0, 0);
    wait_idle(0);

    fork
      begin send(1, 8'h07, 0, 0); wait_idle(1); end
      begin send(2, 8'h07, 0, 0); wait_idle(2); end
    join

    d0 = done_n[0];
    send(0, 8'h3C, 0, 0);
    repeat (10) @(negedge clk);
    data_w[0] = 8'hFF;
    valid_w[0] = 1'b1;
    chk("mid-frame tx_ready", int'(ready_w[0]), 0);
    chk("mid-frame busy", int'(busy_w[0]), 1);
    @(posedge clk);
    #1;
    valid_w[0] = 1'b0;
    wait_idle(0);
    repeat (8) @(negedge clk);
    chk("one done for 0x3C", done_n[0] - d0, 1);

    d0 = done_n[0];
    send(0, 8'h96, 0, 0);
    repeat (17) @(negedge clk);
    #2;
    nrst_w[0] = 1'b0;
    #1;
    chk("abort txd", int'(txd_w[0]), 1);
    chk("abort busy", int'(busy_w[0]), 0);
    chk("abort cnt_clear", int'(clr_w[0]), 1);
    repeat (2) @(negedge clk);
    nrst_w[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("no done after abort", done_n[0] - d0, 0);
    send(0, 8'h81, 0, 0);
    wait_idle(0);

    d0 = done_n[3];
    send(3, 8'h00, 0, 1);
    send(3, 8'hFF, 1, 0);
    wait_idle(3);
    chk("two stop b2b dones", done_n[3] - d0, 2);

    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
      rand_run(3);
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
